// File: rtl/mem_port_pkg.sv
// Shared types and constants for the 16-bit x 1024-word SRAM port master and its helpers.
package mem_port_pkg;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned MEM_DW = 16;

  typedef logic [MEM_AW-1:0] mem_addr_t;
  typedef logic [MEM_DW-1:0] mem_data_t;

  typedef enum logic {
    MPM_INIT = 1'b0,
    MPM_RUN  = 1'b1
  } mpm_state_e;

  typedef struct packed {
    logic      write;
    mem_addr_t addr;
    mem_data_t wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_master_if.sv
// Request/response stream bundle between a requester (master) and mem_port_master (slave).
interface mem_port_master_if #(
  parameter int unsigned AW = mem_port_pkg::MEM_AW,
  parameter int unsigned DW = mem_port_pkg::MEM_DW
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_port_rsp_fifo.sv
// Synchronous response FIFO; DEPTH must be a power of two. Empty head reads as zero.
module mem_port_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/mem_port_master.sv
// SRAM port initiator: valid/ready requests to registered strobes, in-order read return.
// Optional MEM_PORT_MASTER_STATS_EN adds saturating rd_count/wr_count outputs.
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int unsigned AW            = MEM_AW,
  parameter int unsigned DW            = MEM_DW,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned RSP_DEPTH     = 4,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  mem_port_master_if.slave bus,
  output logic             init_done,
  output logic             chip_en,
  output logic             wr_en,
  output logic             rd_en,
  output logic [AW-1:0]    addr,
  output logic [DW-1:0]    wr_data,
  input  logic [DW-1:0]    rd_data
`ifdef MEM_PORT_MASTER_STATS_EN
  ,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count
`endif
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  mpm_state_e        state_q, state_d;
  logic [AW:0]       init_cnt_q, init_cnt_d;
  logic              chip_en_q, chip_en_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic              init_done_q;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic [OW-1:0]     outstanding;
  logic              accept, push, pop;

  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = bus.rsp_valid && bus.rsp_ready;
  assign push   = rd_pipe_q[RD_LAT-1];

  // Credits cover the strobed read, every pipe stage and the FIFO, so a push never overflows.
  always_comb begin
    outstanding = OW'(fifo_cnt) + OW'(rd_en_q);
    for (int i = 0; i < int'(RD_LAT); i++) begin
      outstanding = outstanding + OW'(rd_pipe_q[i]);
    end
  end

  assign bus.req_ready = init_done_q && (outstanding < OW'(RSP_DEPTH));
  assign bus.rsp_valid = !fifo_empty;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    chip_en_d  = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      MPM_INIT: begin
        // Top counter bit marks the last fill write already on the pins.
        if (!init_cnt_q[AW]) begin
          chip_en_d  = 1'b1;
          wr_en_d    = 1'b1;
          wr_data_d  = '0;
          addr_d     = init_cnt_q[AW-1:0];
          init_cnt_d = init_cnt_q + (AW+1)'(1);
        end else begin
          state_d = MPM_RUN;
        end
      end
      MPM_RUN: begin
        if (accept) begin
          chip_en_d = 1'b1;
          wr_en_d   = bus.req_write;
          rd_en_d   = !bus.req_write;
          addr_d    = bus.req_addr;
          if (bus.req_write) begin
            wr_data_d = bus.req_wdata;
          end
        end
      end
      default: state_d = MPM_RUN;
    endcase
  end

  assign rd_pipe_d = (rd_pipe_q << 1) | RD_LAT'(rd_en_q);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= (INIT_ON_RESET != 0) ? MPM_INIT : MPM_RUN;
      init_cnt_q  <= '0;
      chip_en_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rd_pipe_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      chip_en_q   <= chip_en_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      rd_pipe_q   <= rd_pipe_d;
      init_done_q <= (state_d == MPM_RUN);
    end
  end

  assign init_done = init_done_q;
  assign chip_en   = chip_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;

  mem_port_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .DW    (DW)
  ) u_rsp_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (rd_data),
    .pop_i   (pop),
    .rdata_o (bus.rsp_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
                                  !(push && fifo_full && !pop));

`ifdef MEM_PORT_MASTER_STATS_EN
  logic [15:0] rd_count_q, wr_count_q;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (accept) begin
      if (bus.req_write && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (!bus.req_write && (rd_count_q != 16'hFFFF)) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Initiator side of the 16-bit x 1024-word single-port SRAM interface (chip_en/wr_en/rd_en/addr/wr_data/rd_data) used by the memory wrapper hierarchy.
- Converts a valid/ready request stream into SRAM pin strobes.
- Tracks read latency and returns read data in order through a response FIFO with credit-based back-pressure.
- Optionally zero-fills the whole array after reset before accepting traffic.

Parameters:
- AW, 10, SRAM address width (1024 words).
- DW, 16, SRAM data width.
- RD_LAT, 1, cycles from rd_en strobe to rd_data valid; legal 1..3.
- RSP_DEPTH, 4, response FIFO entries; power of 2, at least RD_LAT+1.
- INIT_ON_RESET, 1, 1 = zero-fill all 2^AW words after reset; 0 = go straight to RUN.

Ports:
- clock, input, 1, sole clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, request accepted when req_valid && req_ready.
- req_write, input, 1, 1 = write, 0 = read.
- req_addr, input, AW, word address.
- req_wdata, input, DW, write data.
- rsp_valid, output, 1, read data available.
- rsp_ready, input, 1, consumer accepts read data.
- rsp_rdata, output, DW, read data, in request order.
- init_done, output, 1, high once in RUN state.
- chip_en, output, 1, SRAM chip enable, active high.
- wr_en, output, 1, SRAM write strobe, active high.
- rd_en, output, 1, SRAM read strobe, active high.
- addr, output, AW, SRAM address.
- wr_data, output, DW, SRAM write data.
- rd_data, input, DW, SRAM read data, valid RD_LAT cycles after rd_en.

Behaviour:
- Interface: one clock (clock); reset rst_n is synchronous, active-low. Sampled on the rising edge only.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, chip_en=0, wr_en=0, rd_en=0, addr=0, wr_data=0. Response FIFO is emptied, the read-latency pipe is cleared, and the outstanding count is 0.
- FSM states: INIT, RUN.
  - Reset goes to INIT if INIT_ON_RESET=1, otherwise to RUN.
  - INIT: each cycle drives chip_en=1, wr_en=1, wr_data=0, addr=init counter (0..2^AW-1). After writing address 2^AW-1, goes to RUN. req_ready=0 throughout INIT.
  - INIT takes exactly 1024 cycles (default). init_done rises the cycle after the last init write.
- SRAM strobes are registered. An accepted request drives chip_en plus wr_en or rd_en, with addr/wr_data, in the next cycle, for one cycle only. Idle cycles drive all strobes 0, and addr/wr_data hold their last values.
- Writes are posted: no response.
- Reads: the read-latency shift pipe captures rd_data RD_LAT cycles after the rd_en cycle and pushes it into the response FIFO.
- Credits:
  - outstanding = reads strobed but not yet pushed, plus FIFO occupancy.
  - req_ready = RUN && (outstanding < RSP_DEPTH). Writes use the same gate, which keeps ordering simple.
  - Guarantees the FIFO never overflows; no data is dropped.
- Response FIFO:
  - rsp_valid = FIFO not empty; rsp_rdata = head.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are both performed, so occupancy is unchanged.
  - Push into an empty FIFO is visible on rsp_valid the next cycle (no bypass).
  - Pointers wrap modulo RSP_DEPTH.
- Read latency: minimum from request acceptance to rsp_valid is RD_LAT+2 cycles.
- Back-to-back: one request per cycle sustained while credits remain. A write then a read to the same address on consecutive cycles returns the new data.
- req_valid while req_ready=0: no effect. The requester holds its request (standard valid/ready).
- Reset mid-operation: in-flight reads and FIFO contents are discarded, strobes go to 0 the next cycle, and INIT restarts from address 0.

Optional Feature:
- Macro: MEM_PORT_MASTER_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each counts accepted RUN-state reads or writes and saturates at 16'hFFFF.
  - INIT writes are not counted.
  - Both reset to 0.
- Undefined: ports and logic absent; all other behaviour is identical.

Decomposition:
- Shared package mem_port_pkg holds:
  - localparams MEM_AW=10 and MEM_DW=16;
  - typedef mem_addr_t, mem_data_t;
  - enum mpm_state_e {MPM_INIT, MPM_RUN};
  - a request struct {write, addr, wdata}.
- One sub-module, mem_port_rsp_fifo: synchronous FIFO with parameters DEPTH and DW, ports push/pop/full/empty/count, synchronous active-low reset.

Test Plan:
- INIT_ON_RESET=1, release rst_n: 1024 consecutive wr_en cycles with addr 0..1023 and wr_data=0; init_done=1 at cycle 1025; req_ready=0 until then.
- Write 16'hA5A5 to addr 10'h3FF, then read 10'h3FF next cycle, with rsp_ready=1: rsp_rdata=16'hA5A5, rsp_valid exactly RD_LAT+2 cycles after read acceptance.
- rsp_ready=0 with continuous reads to addrs 0..7: exactly 4 accepted, then req_ready=0. Raise rsp_ready: data returns in order 0,1,2,3 with no loss, and acceptance resumes.
- Simultaneous push and pop with FIFO at 3 entries: occupancy stays 3. Ordering across 20 wrap-arounds is preserved.
- Assert rst_n=0 with 3 reads in flight: next cycle strobes=0, rsp_valid=0. After release, INIT restarts at addr 0 and no stale responses appear.
- MEM_PORT_MASTER_STATS_EN defined: 5 writes and 3 reads after INIT give wr_count=5, rd_count=3. Force 70000 reads: rd_count holds at 16'hFFFF.
